// File: rtl/stopwatch_bcd_pkg.sv
// Shared types and digit limits for the MM:SS BCD stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam int SEC_TENS_MAX = 5;
    localparam int MIN_TENS_MAX = 5;
    localparam int ONES_MAX     = 9;

endpackage

// File: rtl/stopwatch_bcd_digit_counter.sv
// One BCD digit with increment enable; carry marks the wrap from MAX so the next digit advances.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output bcd_t digit,
    output logic carry
);

    bcd_t digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        // Out-of-range values recover to 0 whether or not the digit is being advanced.
        if (clr || digit_q > bcd_t'(MAX)) begin
            digit_d = '0;
        end else if (inc) begin
            digit_d = (digit_q == bcd_t'(MAX)) ? '0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign carry = inc & (digit_q == bcd_t'(MAX));

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch counting rising edges of a divided clock, with run/pause, lap freeze and clear.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_SEC = 500000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       scaledclk,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       lap_active,
    output logic       rollover
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    sw_state_t     state_q, state_d;
    logic          scaledclk_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   lap_q, lap_d;
    logic          rollover_q;

    logic          tick, counting, sec_inc, clear_all, lap_load;
    logic          so_carry, st_carry, mo_carry, mt_carry;
    bcd_t          so, st, mo, mt;
    logic [15:0]   live;

    assign tick     = scaledclk & ~scaledclk_q;
    assign counting = tick & ((state_q == RUN) || (state_q == LAP));
    assign sec_inc  = counting & (presc_q == PW'(TICKS_PER_SEC - 1));
    assign live     = {mt, mo, st, so};

    always_comb begin
        state_d   = state_q;
        clear_all = 1'b0;
        lap_load  = 1'b0;
        if (clear) begin
            state_d   = IDLE;
            clear_all = 1'b1;
        end else begin
            unique case (state_q)
                IDLE:  if (start_stop) state_d = RUN;
                RUN: begin
                    if (start_stop) begin
                        state_d = PAUSE;
                    end else if (lap) begin
                        state_d  = LAP;
                        lap_load = 1'b1;
                    end
                end
                LAP: begin
                    if (start_stop)  state_d = PAUSE;
                    else if (lap)    state_d = RUN;
                end
                PAUSE: if (start_stop) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        presc_d = presc_q;
        if (clear_all) begin
            presc_d = '0;
        end else if (counting) begin
            presc_d = sec_inc ? '0 : presc_q + 1'b1;
        end
        lap_d = lap_q;
        if (clear_all) begin
            lap_d = '0;
        end else if (lap_load) begin
            lap_d = live;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            scaledclk_q <= 1'b0;
            presc_q     <= '0;
            lap_q       <= '0;
            rollover_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            scaledclk_q <= scaledclk;
            presc_q     <= presc_d;
            lap_q       <= lap_d;
            rollover_q  <= mt_carry & ~clear_all;
        end
    end

    bcd_digit_counter #(.MAX(ONES_MAX)) u_sec_ones (
        .clock(clock), .reset_n(reset_n), .clr(clear_all), .inc(sec_inc),
        .digit(so), .carry(so_carry)
    );
    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clock(clock), .reset_n(reset_n), .clr(clear_all), .inc(so_carry),
        .digit(st), .carry(st_carry)
    );
    bcd_digit_counter #(.MAX(ONES_MAX)) u_min_ones (
        .clock(clock), .reset_n(reset_n), .clr(clear_all), .inc(st_carry),
        .digit(mo), .carry(mo_carry)
    );
    bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clock(clock), .reset_n(reset_n), .clr(clear_all), .inc(mo_carry),
        .digit(mt), .carry(mt_carry)
    );

    assign {min_tens, min_ones, sec_tens, sec_ones} = (state_q == LAP) ? lap_q : live;
    assign running    = (state_q == RUN) || (state_q == LAP);
    assign lap_active = (state_q == LAP);
    assign rollover   = rollover_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd with TICKS_PER_SEC=4.
module tb_stopwatch_bcd;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       scaledclk = 1'b0;
    logic       start_stop = 1'b0;
    logic       lap = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, lap_active, rollover;
    logic [15:0] disp;

    int vecs = 0;
    int errs = 0;
    int roll_seen = 0;

    stopwatch_bcd #(.TICKS_PER_SEC(4)) dut (
        .clock(clock), .reset_n(reset_n), .scaledclk(scaledclk),
        .start_stop(start_stop), .lap(lap), .clear(clear),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
        .running(running), .lap_active(lap_active), .rollover(rollover)
    );

    assign disp = {min_tens, min_ones, sec_tens, sec_ones};

    always #5 clock = ~clock;

    always @(negedge clock) if (rollover) roll_seen++;

    task automatic rises(input int n, input int half);
        for (int i = 0; i < n; i++) begin
            @(posedge clock) #1 scaledclk = 1'b1;
            repeat (half - 1) @(posedge clock);
            @(posedge clock) #1 scaledclk = 1'b0;
            repeat (half - 1) @(posedge clock);
        end
    endtask

    task automatic pulse_ss();
        @(posedge clock) #1 start_stop = 1'b1;
        @(posedge clock) #1 start_stop = 1'b0;
    endtask

    task automatic pulse_lap();
        @(posedge clock) #1 lap = 1'b1;
        @(posedge clock) #1 lap = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock) #1 scaledclk = ~scaledclk;
        end
        reset_n = 1'b1;
        scaledclk = 1'b0;
        @(posedge clock) #1;
        vecs++; if (disp !== 16'h0000) begin errs++; $display("FAIL reset_digits got %h want 0000", disp); end
        vecs++; if (running !== 1'b0) begin errs++; $display("FAIL reset_running got %b want 0", running); end
        vecs++; if (rollover !== 1'b0) begin errs++; $display("FAIL reset_rollover got %b want 0", rollover); end
        vecs++; if (lap_active !== 1'b0) begin errs++; $display("FAIL reset_lap_active got %b want 0", lap_active); end
        rises(8, 100);
        vecs++; if (disp !== 16'h0000) begin errs++; $display("FAIL idle_hold got %h want 0000", disp); end
    endtask

    task automatic test_count();
        pulse_ss();
        rises(40, 100);
        vecs++; if (disp !== 16'h0010) begin errs++; $display("FAIL count_10s got %h want 0010", disp); end
        vecs++; if (running !== 1'b1) begin errs++; $display("FAIL count_running got %b want 1", running); end
    endtask

    task automatic test_rollover();
        roll_seen = 0;
        rises(14356, 1);
        vecs++; if (disp !== 16'h5959) begin errs++; $display("FAIL reach_5959 got %h want 5959", disp); end
        vecs++; if (roll_seen !== 0) begin errs++; $display("FAIL early_rollover got %0d want 0", roll_seen); end
        rises(4, 1);
        repeat (3) @(posedge clock);
        #1;
        vecs++; if (disp !== 16'h0000) begin errs++; $display("FAIL wrap_digits got %h want 0000", disp); end
        vecs++; if (roll_seen !== 1) begin errs++; $display("FAIL rollover_cycles got %0d want 1", roll_seen); end
        vecs++; if (running !== 1'b1) begin errs++; $display("FAIL wrap_running got %b want 1", running); end
    endtask

    task automatic test_lap();
        rises(20, 50);
        vecs++; if (disp !== 16'h0005) begin errs++; $display("FAIL pre_lap got %h want 0005", disp); end
        pulse_lap();
        rises(12, 50);
        vecs++; if (disp !== 16'h0005) begin errs++; $display("FAIL lap_frozen got %h want 0005", disp); end
        vecs++; if (lap_active !== 1'b1) begin errs++; $display("FAIL lap_active got %b want 1", lap_active); end
        vecs++; if (running !== 1'b1) begin errs++; $display("FAIL lap_running got %b want 1", running); end
        pulse_lap();
        vecs++; if (disp !== 16'h0008) begin errs++; $display("FAIL lap_release got %h want 0008", disp); end
        vecs++; if (lap_active !== 1'b0) begin errs++; $display("FAIL lap_exit got %b want 0", lap_active); end
    endtask

    task automatic test_pause();
        @(posedge clock) #1 clear = 1'b1;
        @(posedge clock) #1 clear = 1'b0;
        vecs++; if (disp !== 16'h0000) begin errs++; $display("FAIL clear_digits got %h want 0000", disp); end
        pulse_ss();
        rises(14, 50);
        vecs++; if (disp !== 16'h0003) begin errs++; $display("FAIL pre_pause got %h want 0003", disp); end
        pulse_ss();
        vecs++; if (running !== 1'b0) begin errs++; $display("FAIL pause_running got %b want 0", running); end
        rises(20, 50);
        vecs++; if (disp !== 16'h0003) begin errs++; $display("FAIL pause_hold got %h want 0003", disp); end
        pulse_ss();
        rises(2, 50);
        vecs++; if (disp !== 16'h0004) begin errs++; $display("FAIL resume_prescaler got %h want 0004", disp); end
    endtask

    task automatic test_clear_priority();
        rises(3, 50);
        roll_seen = 0;
        @(posedge clock) #1;
        scaledclk = 1'b1; clear = 1'b1; start_stop = 1'b1;
        @(posedge clock) #1;
        clear = 1'b0; start_stop = 1'b0;
        vecs++; if (disp !== 16'h0000) begin errs++; $display("FAIL clr_digits got %h want 0000", disp); end
        vecs++; if (running !== 1'b0) begin errs++; $display("FAIL clr_running got %b want 0", running); end
        repeat (2) @(posedge clock);
        #1 scaledclk = 1'b0;
        vecs++; if (roll_seen !== 0) begin errs++; $display("FAIL clr_rollover got %0d want 0", roll_seen); end
        rises(2, 50);
        vecs++; if (disp !== 16'h0000) begin errs++; $display("FAIL clr_idle got %h want 0000", disp); end
        pulse_ss();
        rises(4, 50);
        vecs++; if (disp !== 16'h0001) begin errs++; $display("FAIL clr_prescaler got %h want 0001", disp); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_rollover();
        test_lap();
        test_pause();
        test_clear_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
